// File: rtl/apx_mult_err_monitor.sv
// Error statistics over a 2^WIN_LOG2-sample window, for an approximate 8x8 multiplier.
// A sample reaches the accumulators 2 edges after it is accepted; done rises 2 edges after the last accept.
// in_ready is high only in RUN while the window is not yet full; nothing upstream is ever stalled mid-window.
module apx_mult_err_monitor #(
    parameter int WIN_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            x,
    input  logic [7:0]            y,
    input  logic [15:0]           z_apx,
    output logic                  busy,
    output logic                  done,
    output logic [16+WIN_LOG2:0]  sum_err,
    output logic [15+WIN_LOG2:0]  sum_abs_err,
    output logic [15:0]           max_abs_err,
    output logic [7:0]            max_x,
    output logic [7:0]            max_y,
    output logic [WIN_LOG2:0]     err_cnt
);

    localparam int CW = WIN_LOG2 + 1;
    localparam logic [CW-1:0] WIN_N = {1'b1, {WIN_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] z;
    } s1_dat_t;

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [16:0] err;
        logic [15:0] abs_err;
    } s2_dat_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   acc_cnt;
    logic            accept;
    logic            clear;

    logic            s1_vld;
    s1_dat_t         s1_dat;
    logic            s2_vld;
    s2_dat_t         s2_dat;

    logic [15:0]     exact_c;
    logic [16:0]     err_c;
    logic [16:0]     neg_c;
    logic [15:0]     abs_c;

    assign in_ready = (state == RUN) && (acc_cnt < WIN_N);
    assign accept   = in_valid && in_ready;
    assign clear    = start && ((state == IDLE) || (state == DONE));
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DRAIN ends once S1 is empty: the S2 sample lands in the accumulators on that same edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (accept && (acc_cnt == WIN_N - CW'(1))) state_nxt = DRAIN;
            DRAIN:   if (!s1_vld) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= '0;
        end else if (clear) begin
            acc_cnt <= '0;
        end else if (accept) begin
            acc_cnt <= acc_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_dat <= '{x: x, y: y, z: z_apx};
            end
        end
    end

    // Error is formed on 17 bits so z_apx - exact never wraps.
    always_comb begin
        exact_c = 16'(s1_dat.x) * 16'(s1_dat.y);
        err_c   = {1'b0, s1_dat.z} - {1'b0, exact_c};
        neg_c   = -err_c;
        abs_c   = err_c[16] ? neg_c[15:0] : err_c[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld <= 1'b0;
            s2_dat <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_dat <= '{x: s1_dat.x, y: s1_dat.y, err: err_c, abs_err: abs_c};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_err     <= '0;
            sum_abs_err <= '0;
            err_cnt     <= '0;
            max_abs_err <= '0;
            max_x       <= '0;
            max_y       <= '0;
        end else if (clear) begin
            sum_err     <= '0;
            sum_abs_err <= '0;
            err_cnt     <= '0;
            max_abs_err <= '0;
            max_x       <= '0;
            max_y       <= '0;
        end else if (s2_vld) begin
            sum_err     <= sum_err + {{WIN_LOG2{s2_dat.err[16]}}, s2_dat.err};
            sum_abs_err <= sum_abs_err + {{WIN_LOG2{1'b0}}, s2_dat.abs_err};
            err_cnt     <= err_cnt + {{WIN_LOG2{1'b0}}, (s2_dat.err != 17'd0)};
            // Strictly greater: on a tie the earliest sample keeps its operands.
            if (s2_dat.abs_err > max_abs_err) begin
                max_abs_err <= s2_dat.abs_err;
                max_x       <= s2_dat.x;
                max_y       <= s2_dat.y;
            end
        end
    end

endmodule

// File: tb/tb_apx_mult_err_monitor.sv
// Directed and randomized checks of apx_mult_err_monitor at window sizes 2, 4, 8 and 1024.
module tb_apx_mult_err_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  start_v;
    logic [3:0]  valid_v;
    logic [7:0]  x, y;
    logic [15:0] z;

    logic [3:0]  rdy_v, busy_v, done_v;
    logic [15:0] max_v [4];
    logic [7:0]  mx_v [4];
    logic [7:0]  my_v [4];

    logic signed [17:0] se1;  logic [16:0] sa1;  logic [1:0]  ec1;
    logic signed [18:0] se2;  logic [17:0] sa2;  logic [2:0]  ec2;
    logic signed [19:0] se3;  logic [18:0] sa3;  logic [3:0]  ec3;
    logic signed [26:0] se10; logic [25:0] sa10; logic [10:0] ec10;

    apx_mult_err_monitor #(.WIN_LOG2(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_valid(valid_v[0]), .in_ready(rdy_v[0]),
        .x(x), .y(y), .z_apx(z), .busy(busy_v[0]), .done(done_v[0]), .sum_err(se1),
        .sum_abs_err(sa1), .max_abs_err(max_v[0]), .max_x(mx_v[0]), .max_y(my_v[0]), .err_cnt(ec1));
    apx_mult_err_monitor #(.WIN_LOG2(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_valid(valid_v[1]), .in_ready(rdy_v[1]),
        .x(x), .y(y), .z_apx(z), .busy(busy_v[1]), .done(done_v[1]), .sum_err(se2),
        .sum_abs_err(sa2), .max_abs_err(max_v[1]), .max_x(mx_v[1]), .max_y(my_v[1]), .err_cnt(ec2));
    apx_mult_err_monitor #(.WIN_LOG2(3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in_valid(valid_v[2]), .in_ready(rdy_v[2]),
        .x(x), .y(y), .z_apx(z), .busy(busy_v[2]), .done(done_v[2]), .sum_err(se3),
        .sum_abs_err(sa3), .max_abs_err(max_v[2]), .max_x(mx_v[2]), .max_y(my_v[2]), .err_cnt(ec3));
    apx_mult_err_monitor #(.WIN_LOG2(10)) u_w10 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .in_valid(valid_v[3]), .in_ready(rdy_v[3]),
        .x(x), .y(y), .z_apx(z), .busy(busy_v[3]), .done(done_v[3]), .sum_err(se10),
        .sum_abs_err(sa10), .max_abs_err(max_v[3]), .max_x(mx_v[3]), .max_y(my_v[3]), .err_cnt(ec10));

    // Common view of whichever instance is selected.
    int     sel;
    longint c_ready, c_busy, c_done, c_sum_err, c_sum_abs, c_cnt, c_max, c_mx, c_my;
    always_comb begin
        c_ready   = longint'(rdy_v[sel]);
        c_busy    = longint'(busy_v[sel]);
        c_done    = longint'(done_v[sel]);
        c_max     = longint'(max_v[sel]);
        c_mx      = longint'(mx_v[sel]);
        c_my      = longint'(my_v[sel]);
        c_sum_err = 0;
        c_sum_abs = 0;
        c_cnt     = 0;
        case (sel)
            0: begin c_sum_err = longint'(se1);  c_sum_abs = longint'(sa1);  c_cnt = longint'(ec1);  end
            1: begin c_sum_err = longint'(se2);  c_sum_abs = longint'(sa2);  c_cnt = longint'(ec2);  end
            2: begin c_sum_err = longint'(se3);  c_sum_abs = longint'(sa3);  c_cnt = longint'(ec3);  end
            default: begin c_sum_err = longint'(se10); c_sum_abs = longint'(sa10); c_cnt = longint'(ec10); end
        endcase
    end

    typedef struct {
        int x;
        int y;
        int z;
    } smp_t;

    smp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   accepts = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic smp_t rnd_smp();
        smp_t s;
        int   p, d;
        s.x = int'($urandom_range(0, 255));
        s.y = int'($urandom_range(0, 255));
        p   = s.x * s.y;
        case ($urandom_range(0, 3))
            0: s.z = p;
            1: s.z = int'($urandom_range(0, 65535));
            default: begin
                d   = int'($urandom_range(0, 600)) - 300;
                s.z = p + d;
                if (s.z < 0) s.z = 0;
                if (s.z > 65535) s.z = 65535;
            end
        endcase
        return s;
    endfunction

    function automatic smp_t mk(input int a, input int b, input int c);
        smp_t s;
        s.x = a; s.y = b; s.z = c;
        return s;
    endfunction

    task automatic fill_rand(input int n);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(rnd_smp());
    endtask

    task automatic do_start();
        valid_v = '0;
        start_v[sel] = 1'b1;
        tick();
        start_v = '0;
        accepts = 0;
        chk("ready_after_start", c_ready, 1);
    endtask

    task automatic feed(input int lo, input int hi, input bit gaps);
        int w;
        for (int i = lo; i < hi; i++) begin
            if (gaps) begin
                valid_v[sel] = 1'b0;
                tick();
            end
            x = 8'(q[i].x);
            y = 8'(q[i].y);
            z = 16'(q[i].z);
            valid_v[sel] = 1'b1;
            w = 0;
            while (c_ready == 0 && w < 50) begin
                tick();
                w++;
            end
            if (w >= 50) chk("ready_wait", c_ready, 1);
            if (c_ready != 0) accepts++;
            tick();
        end
        valid_v[sel] = 1'b0;
    endtask

    // Called one step after the edge that accepted the last sample of the window.
    task automatic finish_window(input string tag);
        longint es = 0, ea = 0, e, a;
        longint ec = 0, em = 0, emx = 0, emy = 0;
        chk({tag, "_ready_drain"}, c_ready, 0);
        chk({tag, "_busy_drain"}, c_busy, 1);
        chk({tag, "_done_e1"}, c_done, 0);
        // Keep offering data while draining; none of it may be taken.
        valid_v[sel] = 1'b1;
        x = 8'd200; y = 8'd200; z = 16'd0;
        if (c_ready != 0) accepts++;
        tick();
        chk({tag, "_done_e2"}, c_done, 0);
        if (c_ready != 0) accepts++;
        tick();
        valid_v[sel] = 1'b0;
        chk({tag, "_done"}, c_done, 1);
        chk({tag, "_busy_done"}, c_busy, 0);
        chk({tag, "_ready_done"}, c_ready, 0);
        chk({tag, "_accepts"}, longint'(accepts), longint'(q.size()));
        foreach (q[i]) begin
            e = longint'(q[i].z) - longint'(q[i].x) * longint'(q[i].y);
            a = (e < 0) ? -e : e;
            es += e;
            ea += a;
            if (e != 0) ec++;
            if (a > em) begin
                em = a; emx = q[i].x; emy = q[i].y;
            end
        end
        chk({tag, "_sum_err"}, c_sum_err, es);
        chk({tag, "_sum_abs"}, c_sum_abs, ea);
        chk({tag, "_err_cnt"}, c_cnt, ec);
        chk({tag, "_max"}, c_max, em);
        chk({tag, "_max_x"}, c_mx, emx);
        chk({tag, "_max_y"}, c_my, emy);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, c_ready, 0);
        chk({tag, "_busy"}, c_busy, 0);
        chk({tag, "_done"}, c_done, 0);
        chk({tag, "_sum_err"}, c_sum_err, 0);
        chk({tag, "_sum_abs"}, c_sum_abs, 0);
        chk({tag, "_err_cnt"}, c_cnt, 0);
        chk({tag, "_max"}, c_max, 0);
        chk({tag, "_max_xy"}, c_mx + c_my, 0);
    endtask

    initial begin
        rst_n = 1'b0; start_v = '0; valid_v = '0; x = '0; y = '0; z = '0; sel = 0;
        tick(); tick();
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            chk_zero($sformatf("reset_w%0d", s));
        end
        rst_n = 1'b1;
        tick();

        // Exact multiplier, window of 4.
        sel = 1;
        do_start();
        q.delete();
        q.push_back(mk(3, 5, 15)); q.push_back(mk(255, 255, 65025));
        q.push_back(mk(0, 9, 0));  q.push_back(mk(17, 17, 289));
        feed(0, 4, 1'b0);
        finish_window("exact");
        chk("exact_done_hold", c_done, 1);

        // Under-estimating multiplier.
        do_start();
        q.delete();
        q.push_back(mk(255, 255, 0)); q.push_back(mk(2, 3, 5));
        q.push_back(mk(1, 1, 1));     q.push_back(mk(4, 4, 20));
        feed(0, 4, 1'b0);
        finish_window("under");
        chk("under_sum_err_const", c_sum_err, -65022);
        chk("under_sum_abs_const", c_sum_abs, 65030);

        // Tie on maximum keeps the first sample.
        sel = 0;
        do_start();
        q.delete();
        q.push_back(mk(2, 2, 6)); q.push_back(mk(3, 1, 5));
        feed(0, 2, 1'b0);
        finish_window("tie");
        chk("tie_max_const", c_max, 2);
        chk("tie_mx_const", c_mx, 2);

        // Bubbles between samples.
        sel = 2;
        do_start();
        fill_rand(8);
        feed(0, 8, 1'b1);
        finish_window("bubble");

        // start pulsed mid-window is ignored.
        do_start();
        fill_rand(8);
        feed(0, 3, 1'b0);
        start_v[sel] = 1'b1;
        tick();
        start_v = '0;
        chk("run_start_busy", c_busy, 1);
        feed(3, 8, 1'b0);
        finish_window("runstart");

        // Reset mid-window aborts everything.
        do_start();
        fill_rand(8);
        feed(0, 3, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        chk_zero("post_reset");
        do_start();
        fill_rand(8);
        feed(0, 8, 1'b0);
        finish_window("fresh");

        // Back-to-back full windows.
        sel = 3;
        do_start();
        fill_rand(1024);
        feed(0, 1024, 1'b0);
        finish_window("big1");
        do_start();
        chk("b2b_clear_abs", c_sum_abs, 0);
        chk("b2b_clear_cnt", c_cnt, 0);
        chk("b2b_clear_max", c_max, 0);
        chk("b2b_done", c_done, 0);
        chk("b2b_busy", c_busy, 1);
        fill_rand(1024);
        feed(0, 1024, 1'b0);
        finish_window("big2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
